// File: rtl/adpcm_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adpcm_channel_sequencer
// Brief    : Queues per-channel key-on/key-off events, picks pending channels
//            round-robin, fetches a pitch, writes the channel register block,
//            then batches start/stop masks to the global register port.
// Revision : 1.0 - initial release
// ============================================================================
module adpcm_channel_sequencer #(
  parameter int CHANNELS  = 8,
  parameter int CH_STRIDE = 8,
  parameter int REG_COUNT = 6,
  localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [CHANNELS-1:0] key_on_i,
  input  logic [CHANNELS-1:0] key_off_i,
  output logic                pitch_request_o,
  input  logic                pitch_valid_i,
  input  logic [15:0]         pitch_data_i,
  output logic [CH_BITS-1:0]  cfg_channel_o,
  output logic [2:0]          cfg_reg_index_o,
  input  logic [15:0]         cfg_data_i,
  output logic [7:0]          ch_write_address_o,
  output logic [15:0]         ch_write_data_o,
  output logic                ch_write_en_o,
  input  logic                ch_write_ready_i,
  output logic                gb_write_address_o,
  output logic [CHANNELS-1:0] gb_write_data_o,
  output logic                gb_write_en_o,
  input  logic                gb_write_busy_i,
  input  logic                gb_write_ready_i,
  output logic                busy_o
);

  localparam logic [2:0] LAST_IDX = 3'(REG_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PITCH = 2'd1,
    S_WRITE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] pend_cfg_q, pend_cfg_d;
  logic [CHANNELS-1:0] pend_start_q, pend_start_d;
  logic [CHANNELS-1:0] pend_stop_q, pend_stop_d;
  logic [CH_BITS-1:0]  last_ch_q, last_ch_d;
  logic [CH_BITS-1:0]  cfg_ch_q, cfg_ch_d;
  logic [2:0]          idx_q, idx_d;
  logic                abort_q, abort_d;
  logic [15:0]         pitch_q, pitch_d;
  logic                pitch_req_q, pitch_req_d;
  logic                gb_we_q, gb_we_d;
  logic                gb_addr_q, gb_addr_d;
  logic [CHANNELS-1:0] gb_data_q, gb_data_d;

  logic                sel_found;
  logic [CH_BITS-1:0]  sel_ch;
  logic [CH_BITS-1:0]  cand;

  // Round-robin search: first pending channel at or after last_ch+1, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    cand      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = CH_BITS'((32'(last_ch_q) + 32'd1 + 32'(i)) % 32'(CHANNELS));
      if (!sel_found && pend_cfg_q[cand]) begin
        sel_found = 1'b1;
        sel_ch    = cand;
      end
    end
  end

  // Next-state logic for the configuration FSM, pending sets and global writer.
  always_comb begin
    state_d      = state_q;
    pend_cfg_d   = pend_cfg_q;
    pend_start_d = pend_start_q;
    pend_stop_d  = pend_stop_q;
    last_ch_d    = last_ch_q;
    cfg_ch_d     = cfg_ch_q;
    idx_d        = idx_q;
    abort_d      = abort_q;
    pitch_d      = pitch_q;
    pitch_req_d  = 1'b0;
    gb_we_d      = gb_we_q;
    gb_addr_d    = gb_addr_q;
    gb_data_d    = gb_data_q;

    // Global writer first: its snapshot clear must not swallow bits set below.
    if (gb_we_q) begin
      if (gb_write_ready_i) gb_we_d = 1'b0;
    end else if (!gb_write_busy_i) begin
      if (|pend_start_q) begin
        gb_we_d      = 1'b1;
        gb_addr_d    = 1'b0;
        gb_data_d    = pend_start_q;
        pend_start_d = '0;
      end else if (|pend_stop_q) begin
        gb_we_d     = 1'b1;
        gb_addr_d   = 1'b1;
        gb_data_d   = pend_stop_q;
        pend_stop_d = '0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          cfg_ch_d             = sel_ch;
          pend_cfg_d[sel_ch]   = 1'b0;
          idx_d                = '0;
          abort_d              = key_off_i[sel_ch];
          pitch_req_d          = 1'b1;
          state_d              = S_PITCH;
        end
      end
      S_PITCH: begin
        if (pitch_valid_i) begin
          pitch_d = pitch_data_i;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (ch_write_ready_i) begin
          if (idx_q == LAST_IDX) begin
            if (!abort_q) pend_start_d[cfg_ch_q] = 1'b1;
            last_ch_d = cfg_ch_q;
            state_d   = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_GAP;
          end
        end
      end
      default: begin
        state_d = S_WRITE;
      end
    endcase

    // A key-off for the channel in flight cancels its start.
    if (state_q != S_IDLE && key_off_i[cfg_ch_q]) abort_d = 1'b1;

    // Key events apply last so that key-off always wins over key-on.
    pend_cfg_d   = (pend_cfg_d | key_on_i) & ~key_off_i;
    pend_start_d = pend_start_d & ~key_off_i;
    pend_stop_d  = pend_stop_d | key_off_i;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      pend_cfg_q   <= '0;
      pend_start_q <= '0;
      pend_stop_q  <= '0;
      last_ch_q    <= '0;
      cfg_ch_q     <= '0;
      idx_q        <= '0;
      abort_q      <= 1'b0;
      pitch_q      <= '0;
      pitch_req_q  <= 1'b0;
      gb_we_q      <= 1'b0;
      gb_addr_q    <= 1'b0;
      gb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_cfg_q   <= pend_cfg_d;
      pend_start_q <= pend_start_d;
      pend_stop_q  <= pend_stop_d;
      last_ch_q    <= last_ch_d;
      cfg_ch_q     <= cfg_ch_d;
      idx_q        <= idx_d;
      abort_q      <= abort_d;
      pitch_q      <= pitch_d;
      pitch_req_q  <= pitch_req_d;
      gb_we_q      <= gb_we_d;
      gb_addr_q    <= gb_addr_d;
      gb_data_q    <= gb_data_d;
    end
  end

  // Write data is forced to zero outside WRITE so reset leaves every output low.
  assign ch_write_en_o      = (state_q == S_WRITE);
  assign ch_write_data_o    = (state_q != S_WRITE) ? 16'h0000 :
                              (idx_q == LAST_IDX)  ? pitch_q : cfg_data_i;
  assign ch_write_address_o = 8'(cfg_ch_q) * 8'(CH_STRIDE) + 8'(idx_q);
  assign cfg_channel_o      = cfg_ch_q;
  assign cfg_reg_index_o    = idx_q;
  assign pitch_request_o    = pitch_req_q;
  assign gb_write_en_o      = gb_we_q;
  assign gb_write_address_o = gb_addr_q;
  assign gb_write_data_o    = gb_data_q;
  assign busy_o             = (state_q != S_IDLE) | (|pend_cfg_q) |
                              (|pend_start_q) | (|pend_stop_q);

endmodule
`default_nettype wire

// File: doc/adpcm_channel_sequencer.md
Name: adpcm_channel_sequencer

Overview:
Parametrised channel-programming sequencer that sits between key-on/key-off event sources and the ics_adpcm register ports. It queues key events for up to CHANNELS channels and arbitrates among pending channels round-robin. For each selected channel it fetches an adjusted pitch, then writes the channel's register block over the ch_write handshake. It then issues batched start/stop writes to the global register port, with cancellation and re-trigger semantics.

Parameters:
CHANNELS, 8, number of ADPCM channels handled (1..16); CH_BITS = max(1, clog2(CHANNELS)).
CH_STRIDE, 8, address stride between channel register blocks.
REG_COUNT, 6, registers per channel, index 0..REG_COUNT-1; index REG_COUNT-1 is pitch.

Ports:
clk  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
key_on  in  CHANNELS  one-cycle key-on pulses, one bit per channel
key_off  in  CHANNELS  one-cycle key-off pulses
pitch_request  out  1  one-cycle pulse requesting pitch for cfg_channel
pitch_valid  in  1  pitch_data valid strobe
pitch_data  in  16  adjusted pitch
cfg_channel  out  CH_BITS  channel being configured
cfg_reg_index  out  3  register index being written
cfg_data  in  16  combinational register value for (cfg_channel, cfg_reg_index), indices below REG_COUNT-1
ch_write_address  out  8  cfg_channel*CH_STRIDE + cfg_reg_index
ch_write_data  out  16  cfg_data, or latched pitch at index REG_COUNT-1
ch_write_en  out  1  channel register write request
ch_write_ready  in  1  write accepted
gb_write_address  out  1  0 = start mask, 1 = stop mask
gb_write_data  out  CHANNELS  channel mask
gb_write_en  out  1  global write request
gb_write_busy  in  1  global port busy
gb_write_ready  in  1  global write accepted
busy  out  1  high whenever state != IDLE or any pending set is nonzero

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0; state IDLE; pending_cfg, pending_start, pending_stop cleared; round-robin pointer 0.
- Reset mid-operation aborts any write immediately; ch_write_en and gb_write_en are 0 the following cycle.
- Every cycle: pending_cfg |= key_on & ~key_off; pending_stop |= key_off.
- key_off clears the matching bits of pending_cfg and pending_start.
- Same channel with key_on and key_off in the same cycle: key_off wins.
- FSM IDLE: if pending_cfg != 0, select the first set bit at or after (last_channel+1) mod CHANNELS. Set cfg_channel to it, clear its pending_cfg bit, set cfg_reg_index=0, clear abort, pulse pitch_request, go to PITCH.
- FSM PITCH: wait for pitch_valid; latch pitch_data; go to WRITE with ch_write_en=1 on the next cycle.
- FSM WRITE: hold ch_write_en, address and data until ch_write_ready.
  - On ready with index < REG_COUNT-1: ch_write_en=0 for one cycle (GAP), index+1, then re-assert.
  - On ready with index = REG_COUNT-1: ch_write_en=0; set pending_start bit unless abort; last_channel = cfg_channel; go to IDLE.
- key_off for cfg_channel during PITCH or WRITE sets abort. The register block still completes, but no start is queued.
- key_on for cfg_channel during configuration re-sets its pending_cfg bit, so the channel is reconfigured afterwards.
- Global writer runs independently of the FSM:
  - When gb_write_en=0 and !gb_write_busy: if pending_start != 0, issue address 0 with that mask and clear the snapshotted bits; else if pending_stop != 0, issue address 1 and clear those bits. Start has priority.
  - Bits arriving on the issue cycle remain pending.
  - gb_write_en stays high until gb_write_ready and drops the cycle after.
- Minimum latency, key_on to first ch_write_en with pitch_valid 1 cycle after the request: 4 cycles.

Test Plan:
- CHANNELS=8. key_on=0x01, pitch_valid 2 cycles after request, pitch_data=0x1A2B, ready immediate → 6 writes at addresses 0..5, address 5 carries 0x1A2B. Then one gb write, address 0, data 0x01.
- key_on=0x81 same cycle, last_channel=0 → channel 7 configured first (addresses 56..61), then channel 0. Starts issued as 0x80 then 0x01, or merged 0x81 if the first gb write is still busy.
- key_off ch0 during PITCH of ch0 → register writes complete, no start for ch0; gb write address 1, data 0x01.
- key_on and key_off for ch3 in the same cycle → no configuration; single stop write, data 0x08.
- gb_write_busy held high 20 cycles while ch1 and ch2 finish → one start write, data 0x06. gb_write_en held until ready.
- reset_n low during WRITE at index 3 → next cycle all outputs 0; after release a new key_on restarts cleanly at index 0.
